// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX line among NUM_REQ byte sources.
// Sends one start / DATA_W data (LSB first) / STOP_BITS stop frame per grant, paced by a 16x baud tick.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_baud_tick_16x,
   input  logic [NUM_REQ-1:0]          i_req,
   input  logic [NUM_REQ*DATA_W-1:0]   i_data,
   output logic [NUM_REQ-1:0]          o_ack,
   output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
   output logic                        o_busy,
   output logic                        o_tx
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int BC_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          tick_q, tick_d;
   logic [BC_W-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [NUM_REQ-1:0]  ack_d;
   logic [ID_W-1:0]     grant_d;
   logic                busy_d, tx_d;

   logic                found;
   logic [ID_W-1:0]     win;
   logic                bit_end;

   // First asserted requester after the last winner, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int idx;
         idx = int'(last_q) + 1 + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && i_req[ID_W'(idx)]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   assign bit_end = i_baud_tick_16x && (tick_q == 4'd15);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      ack_d   = '0;
      grant_d = o_grant_id;
      busy_d  = o_busy;
      tx_d    = o_tx;

      if (state_q != IDLE && i_baud_tick_16x) tick_d = tick_q + 4'd1;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = START;
               shift_d    = i_data[int'(win)*DATA_W +: DATA_W];
               ack_d[win] = 1'b1;
               grant_d    = win;
               last_d     = win;
               busy_d     = 1'b1;
               tx_d       = 1'b0;
               tick_d     = '0;
               bit_d      = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == BC_W'(DATA_W - 1)) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
                  bit_d   = '0;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BC_W'(1);
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q == BC_W'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  bit_d = bit_q + BC_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         last_q     <= ID_W'(NUM_REQ - 1);
         o_ack      <= '0;
         o_grant_id <= '0;
         o_busy     <= 1'b0;
         o_tx       <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values computed above.
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         last_q     <= last_d;
         o_ack      <= ack_d;
         o_grant_id <= grant_d;
         o_busy     <= busy_d;
         o_tx       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4x8N1 instance plus a 2-requester 7-bit, 2-stop-bit instance.
// The line is sampled mid-bit on falling clock edges; a tick arrives every 4 clocks.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   int          tick_div = 0;

   logic [3:0]  req_a = '0;
   logic [31:0] data_a = '0;
   logic [3:0]  ack_a;
   logic [1:0]  gid_a;
   logic        busy_a, tx_a;

   logic [1:0]  req_b = '0;
   logic [13:0] data_b = '0;
   logic [1:0]  ack_b;
   logic [0:0]  gid_b;
   logic        busy_b, tx_b;

   logic        sel2 = 1'b0;
   logic        cur_tx, cur_busy;
   logic [3:0]  cur_ack;

   int total = 0;
   int bad   = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick_16x(tick),
      .i_req(req_a), .i_data(data_a), .o_ack(ack_a),
      .o_grant_id(gid_a), .o_busy(busy_a), .o_tx(tx_a)
   );

   uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(7), .STOP_BITS(2)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_baud_tick_16x(tick),
      .i_req(req_b), .i_data(data_b), .o_ack(ack_b),
      .o_grant_id(gid_b), .o_busy(busy_b), .o_tx(tx_b)
   );

   assign cur_tx   = sel2 ? tx_b   : tx_a;
   assign cur_busy = sel2 ? busy_b : busy_a;
   assign cur_ack  = sel2 ? {2'b00, ack_b} : ack_a;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_div = (tick_div + 1) % 4;
      tick     = (tick_div == 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] frame8(input logic [7:0] b);
      return {22'd0, 1'b1, b, 1'b0};
   endfunction

   // Called on the sample where ack is visible (offset 0); returns mid-bit samples lv[k] taken at offset
   // 32+64k, the offset of the first high sample and the offset where busy first reads low.
   task automatic rx_frame(input int nbits, input logic [3:0] drop, output logic [15:0] lv,
                           output int first_hi, output int end_off, output int extra_ack);
      lv = '0; first_hi = -1; end_off = -1; extra_ack = 0;
      for (int t = 1; t <= 64*nbits + 128; t++) begin
         @(negedge clk);
         if (t == 1) begin
            if (sel2) req_b = req_b & ~drop[1:0];
            else      req_a = req_a & ~drop;
         end
         if (first_hi < 0 && cur_tx === 1'b1) first_hi = t;
         if (cur_ack !== 4'b0000) extra_ack++;
         if (t >= 32 && (t - 32) % 64 == 0 && (t - 32) / 64 < 16) lv[(t - 32) / 64] = cur_tx;
         if (cur_busy === 1'b0) begin
            end_off = t;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] lv;
      int          first_hi, end_off, extra_ack, start_len, viol;
      logic [7:0]  byte_exp;

      // Reset values and idle line.
      repeat (3) @(negedge clk);
      chk("rst_tx",    32'(tx_a),   32'd1);
      chk("rst_busy",  32'(busy_a), 32'd0);
      chk("rst_ack",   32'(ack_a),  32'd0);
      chk("rst_gid",   32'(gid_a),  32'd0);
      chk("rst_tx_b",  32'(tx_b),   32'd1);
      rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0000 || tx_b !== 1'b1 || busy_b !== 1'b0)
            viol++;
      end
      chk("idle_quiet_cycles", 32'(viol), 32'd0);

      // Single requester 1 sending 0xA5.
      data_a = {8'h33, 8'h22, 8'hA5, 8'h00};
      req_a  = 4'b0010;
      @(negedge clk);
      chk("r1_ack",  32'(ack_a),  32'h2);
      chk("r1_gid",  32'(gid_a),  32'd1);
      chk("r1_busy", 32'(busy_a), 32'd1);
      chk("r1_tx",   32'(tx_a),   32'd0);
      rx_frame(9, 4'b0010, lv, first_hi, end_off, extra_ack);
      start_len = end_off - 576;
      chk("r1_line",       32'(lv),                                  frame8(8'hA5));
      chk("r1_start_len",  32'(start_len >= 61 && start_len <= 64),  32'd1);
      chk("r1_bit_exact",  32'(first_hi),                            32'(start_len));
      chk("r1_extra_ack",  32'(extra_ack),                           32'd0);
      chk("r1_end_tx",     32'(tx_a),                                32'd1);
      repeat (5) @(negedge clk);
      chk("r1_after_busy", 32'(busy_a), 32'd0);
      chk("r1_after_gid",  32'(gid_a),  32'd1);

      // All four requesting: rotation 0,1,2,3,0 with a single idle clock between frames.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      data_a = {8'h33, 8'h22, 8'h11, 8'h00};
      req_a  = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         @(negedge clk);
         chk($sformatf("rr_f%0d_ack", f),  32'(ack_a),  32'(4'b0001 << (f % 4)));
         chk($sformatf("rr_f%0d_gid", f),  32'(gid_a),  32'(f % 4));
         chk($sformatf("rr_f%0d_tx0", f),  32'(tx_a),   32'd0);
         rx_frame(9, 4'b0000, lv, first_hi, end_off, extra_ack);
         byte_exp  = 8'(8'h11 * (f % 4));
         start_len = end_off - 576;
         chk($sformatf("rr_f%0d_line", f),  32'(lv),        frame8(byte_exp));
         chk($sformatf("rr_f%0d_len", f),   32'(start_len >= 61 && start_len <= 64), 32'd1);
         chk($sformatf("rr_f%0d_xack", f),  32'(extra_ack), 32'd0);
         chk($sformatf("rr_f%0d_gap", f),   32'(tx_a),      32'd1);
      end
      req_a = 4'b0000;
      repeat (4) @(negedge clk);
      chk("rr_stop_busy", 32'(busy_a), 32'd0);

      // Grant to 2, then 2 and 3 together: 3 wins first, 2 stays pending.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 4'b0100;
      @(negedge clk);
      chk("pr_first_ack", 32'(ack_a), 32'h4);
      chk("pr_first_gid", 32'(gid_a), 32'd2);
      rx_frame(9, 4'b0100, lv, first_hi, end_off, extra_ack);
      chk("pr_first_line", 32'(lv), frame8(8'h22));
      req_a = 4'b1100;
      @(negedge clk);
      chk("pr_second_ack", 32'(ack_a), 32'h8);
      chk("pr_second_gid", 32'(gid_a), 32'd3);
      rx_frame(9, 4'b1000, lv, first_hi, end_off, extra_ack);
      chk("pr_second_line", 32'(lv),        frame8(8'h33));
      chk("pr_second_xack", 32'(extra_ack), 32'd0);
      @(negedge clk);
      chk("pr_third_ack", 32'(ack_a), 32'h4);
      chk("pr_third_gid", 32'(gid_a), 32'd2);
      rx_frame(9, 4'b0100, lv, first_hi, end_off, extra_ack);
      chk("pr_third_line", 32'(lv), frame8(8'h22));
      repeat (4) @(negedge clk);
      chk("pr_idle_ack", 32'(ack_a), 32'd0);

      // 7 data bits, 2 stop bits, data 0x7F, request held for a second frame.
      sel2   = 1'b1;
      data_b = {7'h00, 7'h7F};
      req_b  = 2'b01;
      @(negedge clk);
      chk("w7_ack", 32'(ack_b), 32'h1);
      chk("w7_gid", 32'(gid_b), 32'd0);
      chk("w7_tx0", 32'(tx_b),  32'd0);
      rx_frame(9, 4'b0000, lv, first_hi, end_off, extra_ack);
      start_len = end_off - 576;
      chk("w7_line",      32'(lv), {22'd0, 2'b11, 7'h7F, 1'b0});
      chk("w7_start_len", 32'(start_len >= 61 && start_len <= 64), 32'd1);
      chk("w7_high_run",  32'(end_off - first_hi), 32'd576);
      chk("w7_gap_tx",    32'(tx_b), 32'd1);
      @(negedge clk);
      chk("w7_next_ack",  32'(ack_b), 32'h1);
      chk("w7_next_tx",   32'(tx_b),  32'd0);
      rx_frame(9, 4'b0001, lv, first_hi, end_off, extra_ack);
      chk("w7_next_line", 32'(lv), {22'd0, 2'b11, 7'h7F, 1'b0});
      sel2 = 1'b0;

      // Reset in the middle of the first data bit, then a full resend.
      data_a = {8'h33, 8'h22, 8'h11, 8'h3C};
      req_a  = 4'b0001;
      @(negedge clk);
      chk("mr_ack", 32'(ack_a), 32'h1);
      repeat (100) @(negedge clk);
      chk("mr_pre_busy", 32'(busy_a), 32'd1);
      chk("mr_pre_tx",   32'(tx_a),   32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_async_tx",   32'(tx_a),   32'd1);
      chk("mr_async_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      chk("mr_rst_ack", 32'(ack_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_re_ack", 32'(ack_a), 32'h1);
      chk("mr_re_gid", 32'(gid_a), 32'd0);
      chk("mr_re_tx",  32'(tx_a),  32'd0);
      rx_frame(9, 4'b0001, lv, first_hi, end_off, extra_ack);
      start_len = end_off - 576;
      chk("mr_re_line", 32'(lv), frame8(8'h3C));
      chk("mr_re_len",  32'(start_len >= 61 && start_len <= 64), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
